// File: rtl/raw10_unpacker_if.sv
// Stream bundle between the CSI packet handler, the RAW10 unpacker and the pixel sink.
// Build option RAW10_LEN_CHECK_EN adds len_err to the bundle.
`timescale 1ns/1ps

interface raw10_unpacker_if #(
  parameter int IN_STREAM_WIDTH = 16,
  parameter int CNT_WIDTH       = 16
);
  logic [IN_STREAM_WIDTH-1:0] in_stream;
  logic                       frame_active;
  logic                       frame_valid;
  logic [39:0]                pixel_data;
  logic                       pixel_valid;
  logic                       frame_start;
  logic                       frame_end;
  logic                       line_start;
  logic                       line_end;
  logic                       trunc_err;
  logic [CNT_WIDTH-1:0]       line_pixels;
`ifdef RAW10_LEN_CHECK_EN
  logic                       len_err;

  modport master (
    output in_stream, frame_active, frame_valid,
    input  pixel_data, pixel_valid, frame_start, frame_end,
    input  line_start, line_end, trunc_err, line_pixels, len_err
  );

  modport slave (
    input  in_stream, frame_active, frame_valid,
    output pixel_data, pixel_valid, frame_start, frame_end,
    output line_start, line_end, trunc_err, line_pixels, len_err
  );
`else
  modport master (
    output in_stream, frame_active, frame_valid,
    input  pixel_data, pixel_valid, frame_start, frame_end,
    input  line_start, line_end, trunc_err, line_pixels
  );

  modport slave (
    input  in_stream, frame_active, frame_valid,
    output pixel_data, pixel_valid, frame_start, frame_end,
    output line_start, line_end, trunc_err, line_pixels
  );
`endif

endinterface

// File: rtl/raw10_unpacker.sv
// MIPI RAW10 unpacker: 2 payload bytes per beat in, one 4-pixel word per 5 bytes out.
// Build option RAW10_LEN_CHECK_EN adds the per-line pixel count check (len_err).
`timescale 1ns/1ps

module raw10_unpacker #(
  parameter int IN_STREAM_WIDTH = 16,
`ifdef RAW10_LEN_CHECK_EN
  parameter int LINE_PIXELS     = 640,
`endif
  parameter int CNT_WIDTH       = 16
) (
  input  logic            rxbyteclkhs,
  input  logic            reset_n,
  raw10_unpacker_if.slave bus
);

  localparam int         BUF_BYTES   = 6;
  localparam int         GROUP_BYTES = 5;
  localparam logic [2:0] BEAT_BYTES  = 3'(IN_STREAM_WIDTH / 8);
  localparam logic [CNT_WIDTH:0] PIX_PER_GROUP = (CNT_WIDTH + 1)'(4);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_LINE = 2'd1,
    S_IN_LINE   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic       w_consume;
  logic       w_line_close;
  logic       w_frame_start;
  logic       w_frame_end;

  logic [7:0] r_buf      [BUF_BYTES];
  logic [7:0] w_comb     [BUF_BYTES];
  logic [7:0] w_buf_next [BUF_BYTES];
  logic [2:0] r_fill;
  logic [2:0] w_fill_sum;
  logic [2:0] w_fill_after;
  logic       w_group;
  logic       w_trunc;
  logic [39:0] w_pix;

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH:0]   w_cnt_sum;
  logic [CNT_WIDTH-1:0] w_cnt_after;

  logic [39:0]          r_pixel_data;
  logic                 r_pixel_valid;
  logic                 r_frame_start;
  logic                 r_frame_end;
  logic                 r_line_start;
  logic                 r_line_end;
  logic                 r_trunc_err;
  logic [CNT_WIDTH-1:0] r_line_pixels;

  always_ff @(posedge rxbyteclkhs or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A beat is taken whenever a frame is open, including the beat on which
  // frame_active drops; the line then closes after that beat is absorbed.
  always_comb begin
    w_state_next  = r_state;
    w_consume     = 1'b0;
    w_line_close  = 1'b0;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.frame_active) begin
          w_state_next  = S_WAIT_LINE;
          w_frame_start = 1'b1;
        end
      end
      S_WAIT_LINE: begin
        w_consume = bus.frame_valid;
        if (!bus.frame_active) begin
          w_state_next = S_IDLE;
          w_frame_end  = 1'b1;
          w_line_close = bus.frame_valid;
        end else if (bus.frame_valid) begin
          w_state_next = S_IN_LINE;
        end
      end
      S_IN_LINE: begin
        w_consume = bus.frame_valid;
        if (!bus.frame_active) begin
          w_state_next = S_IDLE;
          w_frame_end  = 1'b1;
          w_line_close = 1'b1;
        end else if (!bus.frame_valid) begin
          w_state_next = S_WAIT_LINE;
          w_line_close = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Byte view after appending this beat at the fill point; older bytes stay below it.
  genvar gi;
  generate
    for (gi = 0; gi < BUF_BYTES; gi++) begin : g_comb
      assign w_comb[gi] = (3'(gi) == r_fill)         ? bus.in_stream[7:0]  :
                          (3'(gi) == r_fill + 3'd1)  ? bus.in_stream[15:8] :
                                                       r_buf[gi];
      if (gi + GROUP_BYTES < BUF_BYTES) begin : g_keep
        assign w_buf_next[gi] = w_group ? w_comb[gi + GROUP_BYTES] : w_comb[gi];
      end else begin : g_drop
        assign w_buf_next[gi] = w_group ? 8'h00 : w_comb[gi];
      end
    end
  endgenerate

  assign w_fill_sum   = r_fill + BEAT_BYTES;
  assign w_group      = w_consume && (w_fill_sum >= 3'(GROUP_BYTES));
  assign w_fill_after = !w_consume ? r_fill :
                        w_group    ? w_fill_sum - 3'(GROUP_BYTES) :
                                     w_fill_sum;
  assign w_trunc      = w_line_close && (w_fill_after != 3'd0);

  // Byte 4 of a group carries the two LSBs of each of the four pixels.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      assign w_pix[gi*10 +: 10] = {w_comb[gi], w_comb[4][2*gi +: 2]};
    end
  endgenerate

  always_ff @(posedge rxbyteclkhs or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BUF_BYTES; i++) begin
        r_buf[i] <= 8'h00;
      end
      r_fill <= 3'd0;
    end else begin
      if (w_consume) begin
        for (int i = 0; i < BUF_BYTES; i++) begin
          r_buf[i] <= w_buf_next[i];
        end
      end
      r_fill <= w_line_close ? 3'd0 : w_fill_after;
    end
  end

  assign w_cnt_sum   = {1'b0, r_cnt} + PIX_PER_GROUP;
  assign w_cnt_after = !w_group            ? r_cnt :
                       w_cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} :
                                              w_cnt_sum[CNT_WIDTH-1:0];

  always_ff @(posedge rxbyteclkhs or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_line_close ? '0 : w_cnt_after;
    end
  end

  // The counter only reads zero before the first group of a line, as it saturates instead of wrapping.
  always_ff @(posedge rxbyteclkhs or negedge reset_n) begin
    if (!reset_n) begin
      r_pixel_data  <= '0;
      r_pixel_valid <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_line_start  <= 1'b0;
      r_line_end    <= 1'b0;
      r_trunc_err   <= 1'b0;
      r_line_pixels <= '0;
    end else begin
      r_pixel_valid <= w_group;
      r_pixel_data  <= w_group ? w_pix : 40'd0;
      r_line_start  <= w_group && (r_cnt == '0);
      r_line_end    <= w_line_close;
      r_trunc_err   <= w_trunc;
      r_frame_start <= w_frame_start;
      r_frame_end   <= w_frame_end;
      if (w_line_close) begin
        r_line_pixels <= w_cnt_after;
      end
    end
  end

  assign bus.pixel_data  = r_pixel_data;
  assign bus.pixel_valid = r_pixel_valid;
  assign bus.frame_start = r_frame_start;
  assign bus.frame_end   = r_frame_end;
  assign bus.line_start  = r_line_start;
  assign bus.line_end    = r_line_end;
  assign bus.trunc_err   = r_trunc_err;
  assign bus.line_pixels = r_line_pixels;

`ifdef RAW10_LEN_CHECK_EN
  localparam logic [CNT_WIDTH-1:0] LINE_PIXELS_C = CNT_WIDTH'(LINE_PIXELS);

  logic r_len_err;

  always_ff @(posedge rxbyteclkhs or negedge reset_n) begin
    if (!reset_n) begin
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= w_line_close && (w_cnt_after != LINE_PIXELS_C);
    end
  end

  assign bus.len_err = r_len_err;
`endif

endmodule

// File: tb/tb_raw10_unpacker.sv
// Directed bench for raw10_unpacker: decode, line/frame pulses, truncation, async reset.
// Build with RAW10_LEN_CHECK_EN to also exercise len_err (LINE_PIXELS=16).
`timescale 1ns/1ps

module tb_raw10_unpacker;

  localparam int CNT_WIDTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  raw10_unpacker_if #(.IN_STREAM_WIDTH(16), .CNT_WIDTH(CNT_WIDTH)) bus ();

  raw10_unpacker #(
    .IN_STREAM_WIDTH(16),
`ifdef RAW10_LEN_CHECK_EN
    .LINE_PIXELS(16),
`endif
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .rxbyteclkhs(clk),
    .reset_n    (rst_n),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int c_pv, c_ls, c_le, c_fs, c_fe;

  logic [39:0] exp_t1;
  logic [39:0] exp_t2a;
  logic [39:0] exp_t2b;
  logic [39:0] exp_t4b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
      $display("ok   %s = 0x%0h", tag, obs);
    end else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic fa, input logic fv, input logic [15:0] d);
    bus.frame_active = fa;
    bus.frame_valid  = fv;
    bus.in_stream    = d;
    @(posedge clk);
    #1;
    c_pv += int'(bus.pixel_valid);
    c_ls += int'(bus.line_start);
    c_le += int'(bus.line_end);
    c_fs += int'(bus.frame_start);
    c_fe += int'(bus.frame_end);
  endtask

  task automatic clr_counts();
    c_pv = 0; c_ls = 0; c_le = 0; c_fs = 0; c_fe = 0;
  endtask

  task automatic chk_pulses_low(input string tag);
    chk({tag, ".pixel_valid"}, 64'(bus.pixel_valid), 64'd0);
    chk({tag, ".pixel_data"},  64'(bus.pixel_data),  64'd0);
    chk({tag, ".line_start"},  64'(bus.line_start),  64'd0);
    chk({tag, ".line_end"},    64'(bus.line_end),    64'd0);
    chk({tag, ".trunc_err"},   64'(bus.trunc_err),   64'd0);
    chk({tag, ".frame_start"}, 64'(bus.frame_start), 64'd0);
    chk({tag, ".frame_end"},   64'(bus.frame_end),   64'd0);
`ifdef RAW10_LEN_CHECK_EN
    chk({tag, ".len_err"},     64'(bus.len_err),     64'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t1  = {10'h113, 10'h0CE, 10'h089, 10'h044};
    exp_t2a = {10'h010, 10'h00C, 10'h009, 10'h005};
    exp_t2b = {10'h024, 10'h020, 10'h01E, 10'h01A};
    exp_t4b = {10'h266, 10'h222, 10'h1DE, 10'h19A};
    clr_counts();

    bus.frame_active = 1'b0;
    bus.frame_valid  = 1'b0;
    bus.in_stream    = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk_pulses_low("reset");
    chk("reset.line_pixels", 64'(bus.line_pixels), 64'd0);
    rst_n = 1'b1;

    // Frame opens
    cyc(1'b1, 1'b0, 16'h0000);
    chk("fs.frame_start", 64'(bus.frame_start), 64'd1);
    cyc(1'b1, 1'b0, 16'h0000);
    chk("fs.pulse_width", 64'(bus.frame_start), 64'd0);

    // 3-beat line: one group, then one residual byte dropped
    cyc(1'b1, 1'b1, 16'h2211);
    chk("t1.pv_beat1", 64'(bus.pixel_valid), 64'd0);
    cyc(1'b1, 1'b1, 16'h4433);
    chk("t1.pv_beat2", 64'(bus.pixel_valid), 64'd0);
    cyc(1'b1, 1'b1, 16'h5AE4);
    chk("t1.pixel_valid", 64'(bus.pixel_valid), 64'd1);
    chk("t1.line_start",  64'(bus.line_start),  64'd1);
    chk("t1.pixel_data",  64'(bus.pixel_data),  64'(exp_t1));
    cyc(1'b1, 1'b0, 16'h0000);
    chk("t1.line_end",    64'(bus.line_end),    64'd1);
    chk("t1.trunc_err",   64'(bus.trunc_err),   64'd1);
    chk("t1.line_pixels", 64'(bus.line_pixels), 64'd4);
    chk("t1.pv_idle",     64'(bus.pixel_valid), 64'd0);
`ifdef RAW10_LEN_CHECK_EN
    chk("t1.len_err",     64'(bus.len_err),     64'd1);
`endif
    cyc(1'b1, 1'b0, 16'h0000);
    chk("t1.le_pulse",    64'(bus.line_end),    64'd0);

    // 10-beat line (20 bytes), bytes 01..14; must start from an empty buffer
    clr_counts();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, {8'(2*i + 2), 8'(2*i + 1)});
      if (i == 2) begin
        chk("t2.g0_data",       64'(bus.pixel_data), 64'(exp_t2a));
        chk("t2.g0_line_start", 64'(bus.line_start), 64'd1);
      end
      if (i == 4) begin
        chk("t2.g1_data",       64'(bus.pixel_data), 64'(exp_t2b));
        chk("t2.g1_line_start", 64'(bus.line_start), 64'd0);
      end
      if (i == 9) begin
        chk("t2.last_beat_pv",  64'(bus.pixel_valid), 64'd1);
      end
    end
    cyc(1'b1, 1'b0, 16'h0000);
    chk("t2.line_end",    64'(bus.line_end),    64'd1);
    chk("t2.trunc_err",   64'(bus.trunc_err),   64'd0);
    chk("t2.line_pixels", 64'(bus.line_pixels), 64'd16);
`ifdef RAW10_LEN_CHECK_EN
    chk("t2.len_err",     64'(bus.len_err),     64'd0);
`endif
    chk("t2.n_pixel_valid", 64'(c_pv), 64'd4);
    chk("t2.n_line_start",  64'(c_ls), 64'd1);
    chk("t2.n_line_end",    64'(c_le), 64'd1);

    // 2-beat line: 4 bytes stuck in the buffer, no group
    clr_counts();
    cyc(1'b1, 1'b1, 16'h1111);
    cyc(1'b1, 1'b1, 16'h2222);
    cyc(1'b1, 1'b0, 16'h0000);
    chk("t3.line_end",     64'(bus.line_end),    64'd1);
    chk("t3.trunc_err",    64'(bus.trunc_err),   64'd1);
    chk("t3.line_pixels",  64'(bus.line_pixels), 64'd0);
    chk("t3.n_pixel_valid", 64'(c_pv), 64'd0);
    chk("t3.n_line_start",  64'(c_ls), 64'd0);

    // Close the frame with no line open, then frame_valid in IDLE is ignored
    cyc(1'b0, 1'b0, 16'h0000);
    chk("fe.frame_end", 64'(bus.frame_end), 64'd1);
    chk("fe.line_end",  64'(bus.line_end),  64'd0);
    cyc(1'b0, 1'b1, 16'hFFFF);
    cyc(1'b0, 1'b1, 16'hFFFF);
    chk_pulses_low("idle_fv");

    // Two-line frame; second line's last beat coincides with frame_active falling
    clr_counts();
    cyc(1'b1, 1'b0, 16'h0000);
    cyc(1'b1, 1'b1, 16'h2211);
    cyc(1'b1, 1'b1, 16'h4433);
    cyc(1'b1, 1'b1, 16'h66E4);
    chk("t4.a_g0_data", 64'(bus.pixel_data), 64'(exp_t1));
    cyc(1'b1, 1'b1, 16'h8877);
    cyc(1'b1, 1'b1, 16'hAA99);
    chk("t4.a_g1_data", 64'(bus.pixel_data), 64'(exp_t4b));
    cyc(1'b1, 1'b0, 16'h0000);
    cyc(1'b1, 1'b1, 16'h2211);
    cyc(1'b1, 1'b1, 16'h4433);
    cyc(1'b1, 1'b1, 16'h66E4);
    cyc(1'b1, 1'b1, 16'h8877);
    cyc(1'b0, 1'b1, 16'hAA99);
    chk("t4.b_pixel_valid", 64'(bus.pixel_valid), 64'd1);
    chk("t4.b_pixel_data",  64'(bus.pixel_data),  64'(exp_t4b));
    chk("t4.b_line_end",    64'(bus.line_end),    64'd1);
    chk("t4.b_frame_end",   64'(bus.frame_end),   64'd1);
    chk("t4.b_trunc_err",   64'(bus.trunc_err),   64'd0);
    chk("t4.b_line_pixels", 64'(bus.line_pixels), 64'd8);
    cyc(1'b0, 1'b0, 16'h0000);
    chk_pulses_low("t4.idle");
    chk("t4.n_frame_start", 64'(c_fs), 64'd1);
    chk("t4.n_frame_end",   64'(c_fe), 64'd1);
    chk("t4.n_line_start",  64'(c_ls), 64'd2);
    chk("t4.n_line_end",    64'(c_le), 64'd2);

    // frame_active re-rises one cycle after falling
    cyc(1'b1, 1'b0, 16'h0000);
    chk("rr.fs1", 64'(bus.frame_start), 64'd1);
    cyc(1'b0, 1'b0, 16'h0000);
    chk("rr.fe",  64'(bus.frame_end),   64'd1);
    chk("rr.fs_low", 64'(bus.frame_start), 64'd0);
    cyc(1'b1, 1'b0, 16'h0000);
    chk("rr.fs2", 64'(bus.frame_start), 64'd1);
    chk("rr.fe_low", 64'(bus.frame_end), 64'd0);

    // Asynchronous reset on beat 2 of a line
    cyc(1'b1, 1'b1, 16'h2211);
    cyc(1'b1, 1'b1, 16'h4433);
    chk("t5.line_pixels_before", 64'(bus.line_pixels), 64'd8);
    #2;
    rst_n = 1'b0;
    #1;
    chk_pulses_low("t5.async");
    chk("t5.async.line_pixels", 64'(bus.line_pixels), 64'd0);
    cyc(1'b1, 1'b1, 16'h6655);
    cyc(1'b1, 1'b1, 16'h6655);
    chk_pulses_low("t5.held");
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 16'h0000);
    chk("t5.frame_start", 64'(bus.frame_start), 64'd1);
    chk("t5.no_line_end", 64'(bus.line_end),    64'd0);
    chk("t5.no_frame_end", 64'(bus.frame_end),  64'd0);
    cyc(1'b1, 1'b1, 16'h2211);
    cyc(1'b1, 1'b1, 16'h4433);
    cyc(1'b1, 1'b1, 16'h00E4);
    chk("t5.pixel_data", 64'(bus.pixel_data), 64'(exp_t1));
    chk("t5.line_start", 64'(bus.line_start), 64'd1);
    cyc(1'b1, 1'b0, 16'h0000);
    chk("t5.line_pixels", 64'(bus.line_pixels), 64'd4);

    // 13-beat line (26 bytes): 5 groups, one residual byte
    for (int i = 0; i < 13; i++) begin
      cyc(1'b1, 1'b1, {8'(2*i + 2), 8'(2*i + 1)});
    end
    cyc(1'b1, 1'b0, 16'h0000);
    chk("t6.line_end",    64'(bus.line_end),    64'd1);
    chk("t6.trunc_err",   64'(bus.trunc_err),   64'd1);
    chk("t6.line_pixels", 64'(bus.line_pixels), 64'd20);
`ifdef RAW10_LEN_CHECK_EN
    chk("t6.len_err",     64'(bus.len_err),     64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
